// File: rtl/ascon_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : ascon_arbiter_if
//  Description : Bundle between the requesters/core snoop side and the
//                ascon_arbiter. The arbiter uses the slave modport. The
//                requester/core environment uses the master modport.
//                  req        - per-requester ownership request
//                  gnt/gnt_id - one-hot grant and owner index
//                  busy       - arbiter not idle
//                  op_done    - completion pulse
//                  timeout    - watchdog abort pulse
//                  core_rst   - reset to the shared ascon_core
//                  key_*, bdi_*, bdo_*, auth_valid - snooped core handshakes
//  Revision    : 1.0 - initial release
// ============================================================================
interface ascon_arbiter_if #(
    parameter int N_REQ = 4
) ();
    localparam int c_IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] gnt;
    logic [c_IDW-1:0] gnt_id;
    logic             busy;
    logic             op_done;
    logic             timeout;
    logic             core_rst;
    logic             key_valid;
    logic             key_ready;
    logic             bdi_valid;
    logic             bdi_ready;
    logic             bdo_valid;
    logic             bdo_ready;
    logic             bdo_eot;
    logic [3:0]       bdo_type;
    logic             auth_valid;

    modport master (
        output req, key_valid, key_ready, bdi_valid, bdi_ready,
               bdo_valid, bdo_ready, bdo_eot, bdo_type, auth_valid,
        input  gnt, gnt_id, busy, op_done, timeout, core_rst
    );

    modport slave (
        input  req, key_valid, key_ready, bdi_valid, bdi_ready,
               bdo_valid, bdo_ready, bdo_eot, bdo_type, auth_valid,
        output gnt, gnt_id, busy, op_done, timeout, core_rst
    );
endinterface
`default_nettype wire

// File: rtl/ascon_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : ascon_arbiter
//  Description : Round-robin arbiter that hands one ascon_core to one of
//                N_REQ requesters at a time. Ownership ends on a tag/hash
//                output beat, on an auth_valid rising edge, when the owner
//                withdraws before its first handshake, or on a watchdog
//                abort (which then holds core_rst for FLUSH_CYC cycles).
//  Ports       : clk, rst (sync, active-high)
//                bus (ascon_arbiter_if.slave) - requests, grants, status
//                pulses, core_rst and the snooped core handshakes
//  Revision    : 1.0 - initial release
// ============================================================================
module ascon_arbiter #(
    parameter int         N_REQ       = 4,
    parameter int         TIMEOUT_CYC = 1024,
    parameter int         FLUSH_CYC   = 2,
    // Output segment types that terminate an operation (config_core.vh)
    parameter logic [3:0] D_TAG       = 4'd4,
    parameter logic [3:0] D_HASH      = 4'd5
) (
    input  wire logic      clk,
    input  wire logic      rst,
    ascon_arbiter_if.slave bus
);
    localparam int c_IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int c_SW  = c_IDW + 1;
    localparam int c_WDW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam int c_FLW = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;

    localparam logic [c_IDW-1:0] c_LAST_RST = c_IDW'(N_REQ - 1);
    localparam logic [c_WDW-1:0] c_WD_LIMIT = c_WDW'(TIMEOUT_CYC - 1);
    localparam logic [c_FLW-1:0] c_FL_LAST  = c_FLW'(FLUSH_CYC - 1);
    localparam logic [c_SW-1:0]  c_NREQ     = c_SW'(N_REQ);
    localparam logic [N_REQ-1:0] c_ONE      = N_REQ'(1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_GRANT  = 2'd1,
        S_ACTIVE = 2'd2,
        S_FLUSH  = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [N_REQ-1:0] r_gnt;
    logic [N_REQ-1:0] w_gnt_nxt;
    logic [c_IDW-1:0] r_gnt_id;
    logic [c_IDW-1:0] w_gnt_id_nxt;
    logic [c_IDW-1:0] r_last_owner;
    logic [c_IDW-1:0] w_last_nxt;
    logic [c_WDW-1:0] r_wdog;
    logic [c_WDW-1:0] w_wdog_nxt;
    logic [c_FLW-1:0] r_flush_cnt;
    logic [c_FLW-1:0] w_flush_nxt;
    logic             r_auth_prev;
    logic             w_op_done;
    logic             w_timeout;

    // ------------------------------------------------------------------
    // Snooped handshakes
    // ------------------------------------------------------------------
    logic w_key_hs;
    logic w_bdi_hs;
    logic w_bdo_hs;
    logic w_any_hs;
    logic w_start_hs;
    logic w_final_beat;
    logic w_auth_rise;
    logic w_complete;
    logic w_wd_expired;

    assign w_key_hs     = bus.key_valid & bus.key_ready;
    assign w_bdi_hs     = bus.bdi_valid & bus.bdi_ready;
    assign w_bdo_hs     = bus.bdo_valid & bus.bdo_ready;
    assign w_any_hs     = w_key_hs | w_bdi_hs | w_bdo_hs;
    assign w_start_hs   = w_key_hs | w_bdi_hs;
    assign w_final_beat = w_bdo_hs & bus.bdo_eot &
                          ((bus.bdo_type == D_TAG) | (bus.bdo_type == D_HASH));
    // r_auth_prev follows auth_valid every cycle, so a level that is already
    // high when a new owner is granted never looks like a fresh edge.
    assign w_auth_rise  = bus.auth_valid & ~r_auth_prev;
    assign w_complete   = w_final_beat | w_auth_rise;
    // Current cycle is the TIMEOUT_CYC-th consecutive one without a handshake.
    assign w_wd_expired = (r_wdog == c_WD_LIMIT) & ~w_any_hs;

    // ------------------------------------------------------------------
    // Round-robin pick: first set req bit after the last owner
    // ------------------------------------------------------------------
    logic             w_found;
    logic [c_IDW-1:0] w_sel;
    logic [c_SW-1:0]  w_sum;

    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        w_sum   = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            w_sum = {1'b0, r_last_owner} + c_SW'(i);
            if (w_sum >= c_NREQ) begin
                w_sum = w_sum - c_NREQ;
            end
            if (!w_found && bus.req[w_sum[c_IDW-1:0]]) begin
                w_found = 1'b1;
                w_sel   = w_sum[c_IDW-1:0];
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state and outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt  = r_state;
        w_gnt_nxt    = r_gnt;
        w_gnt_id_nxt = r_gnt_id;
        w_last_nxt   = r_last_owner;
        w_wdog_nxt   = r_wdog;
        w_flush_nxt  = r_flush_cnt;
        w_op_done    = 1'b0;
        w_timeout    = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_wdog_nxt = '0;
                if (w_found) begin
                    w_state_nxt  = S_GRANT;
                    w_gnt_nxt    = c_ONE << w_sel;
                    w_gnt_id_nxt = w_sel;
                end
            end

            S_GRANT: begin
                w_wdog_nxt = w_any_hs ? '0 : r_wdog + 1'b1;
                if (w_start_hs) begin
                    w_state_nxt = S_ACTIVE;
                end else if (!bus.req[r_gnt_id]) begin
                    w_state_nxt = S_IDLE;
                    w_gnt_nxt   = '0;
                    w_last_nxt  = r_gnt_id;
                end else if (w_wd_expired) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = S_FLUSH;
                    w_gnt_nxt   = '0;
                    w_last_nxt  = r_gnt_id;
                    w_flush_nxt = '0;
                end
            end

            S_ACTIVE: begin
                w_wdog_nxt = w_any_hs ? '0 : r_wdog + 1'b1;
                // Completion is checked first so it wins over a same-cycle expiry.
                if (w_complete) begin
                    w_op_done   = 1'b1;
                    w_state_nxt = S_IDLE;
                    w_gnt_nxt   = '0;
                    w_last_nxt  = r_gnt_id;
                end else if (w_wd_expired) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = S_FLUSH;
                    w_gnt_nxt   = '0;
                    w_last_nxt  = r_gnt_id;
                    w_flush_nxt = '0;
                end
            end

            S_FLUSH: begin
                w_gnt_nxt = '0;
                if (r_flush_cnt == c_FL_LAST) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_flush_nxt = r_flush_cnt + 1'b1;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
                w_gnt_nxt   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_gnt        <= '0;
            r_gnt_id     <= '0;
            r_last_owner <= c_LAST_RST;
            r_wdog       <= '0;
            r_flush_cnt  <= '0;
            r_auth_prev  <= 1'b0;
        end else begin
            r_gnt        <= w_gnt_nxt;
            r_gnt_id     <= w_gnt_id_nxt;
            r_last_owner <= w_last_nxt;
            r_wdog       <= w_wdog_nxt;
            r_flush_cnt  <= w_flush_nxt;
            r_auth_prev  <= bus.auth_valid;
        end
    end

    // A reset in the middle of an operation aborts silently.
    assign bus.gnt      = r_gnt;
    assign bus.gnt_id   = r_gnt_id;
    assign bus.busy     = (r_state != S_IDLE);
    assign bus.op_done  = w_op_done & ~rst;
    assign bus.timeout  = w_timeout & ~rst;
    assign bus.core_rst = rst | (r_state == S_FLUSH);

endmodule
`default_nettype wire

// File: tb/tb_ascon_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ascon_arbiter
//  Description : Directed vector table plus timeout / completion-vs-timeout
//                sequences for ascon_arbiter (N_REQ=4, TIMEOUT_CYC=16,
//                FLUSH_CYC=2).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ascon_arbiter;
    localparam logic [3:0] T = 4'd4;   // D_TAG
    localparam logic [3:0] H = 4'd5;   // D_HASH
    localparam logic [3:0] M = 4'd3;   // message segment, not terminal

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ascon_arbiter_if #(.N_REQ(4)) bus ();

    ascon_arbiter #(
        .N_REQ       (4),
        .TIMEOUT_CYC (16),
        .FLUSH_CYC   (2),
        .D_TAG       (T),
        .D_HASH      (H)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic       rst;
        logic [3:0] req;
        logic       khs;
        logic       bhs;
        logic       ov;
        logic       ordy;
        logic       eot;
        logic [3:0] typ;
        logic       auth;
        logic [3:0] e_gnt;
        logic [1:0] e_id;
        logic       e_busy;
        logic       e_done;
        logic       e_to;
        logic       e_crst;
    } vec_t;

    vec_t vecs [33];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r, input logic [3:0] rq, input logic khs,
                         input logic bhs, input logic ov, input logic ordy,
                         input logic eot, input logic [3:0] typ, input logic auth);
        rst            = r;
        bus.req        = rq;
        bus.key_valid  = khs;
        bus.key_ready  = khs;
        bus.bdi_valid  = bhs;
        bus.bdi_ready  = bhs;
        bus.bdo_valid  = ov;
        bus.bdo_ready  = ordy;
        bus.bdo_eot    = eot;
        bus.bdo_type   = typ;
        bus.auth_valid = auth;
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        //           rst req     khs  bhs  ov   ordy eot  typ  auth   gnt     id    busy done to   crst
        vecs[0]  = '{1'b1, 4'b0000, 1'b0,1'b0,1'b0,1'b0,1'b0,4'd0,1'b0, 4'b0000,2'd0,1'b0,1'b0,1'b0,1'b1};
        vecs[1]  = '{1'b0, 4'b1010, 1'b0,1'b0,1'b0,1'b0,1'b0,4'd0,1'b0, 4'b0000,2'd0,1'b0,1'b0,1'b0,1'b0};
        vecs[2]  = '{1'b0, 4'b1010, 1'b1,1'b0,1'b0,1'b0,1'b0,4'd0,1'b0, 4'b0010,2'd1,1'b1,1'b0,1'b0,1'b0};
        vecs[3]  = '{1'b0, 4'b1010, 1'b0,1'b0,1'b0,1'b0,1'b0,4'd0,1'b0, 4'b0010,2'd1,1'b1,1'b0,1'b0,1'b0};
        vecs[4]  = '{1'b0, 4'b1010, 1'b0,1'b0,1'b1,1'b1,1'b1,T,   1'b0, 4'b0010,2'd1,1'b1,1'b1,1'b0,1'b0};
        vecs[5]  = '{1'b0, 4'b1010, 1'b0,1'b0,1'b0,1'b0,1'b0,4'd0,1'b0, 4'b0000,2'd0,1'b0,1'b0,1'b0,1'b0};
        vecs[6]  = '{1'b0, 4'b1010, 1'b0,1'b1,1'b0,1'b0,1'b0,4'd0,1'b0, 4'b1000,2'd3,1'b1,1'b0,1'b0,1'b0};
        vecs[7]  = '{1'b0, 4'b1010, 1'b0,1'b0,1'b1,1'b1,1'b1,M,   1'b0, 4'b1000,2'd3,1'b1,1'b0,1'b0,1'b0};
        vecs[8]  = '{1'b0, 4'b1010, 1'b0,1'b0,1'b1,1'b1,1'b1,H,   1'b0, 4'b1000,2'd3,1'b1,1'b1,1'b0,1'b0};
        vecs[9]  = '{1'b0, 4'b0001, 1'b0,1'b0,1'b0,1'b0,1'b0,4'd0,1'b0, 4'b0000,2'd0,1'b0,1'b0,1'b0,1'b0};
        vecs[10] = '{1'b0, 4'b0001, 1'b1,1'b0,1'b0,1'b0,1'b0,4'd0,1'b0, 4'b0001,2'd0,1'b1,1'b0,1'b0,1'b0};
        vecs[11] = '{1'b0, 4'b0001, 1'b0,1'b0,1'b1,1'b0,1'b1,T,   1'b0, 4'b0001,2'd0,1'b1,1'b0,1'b0,1'b0};
        vecs[12] = '{1'b0, 4'b0001, 1'b0,1'b0,1'b1,1'b1,1'b1,T,   1'b0, 4'b0001,2'd0,1'b1,1'b1,1'b0,1'b0};
        vecs[13] = '{1'b0, 4'b0000, 1'b0,1'b0,1'b0,1'b0,1'b0,4'd0,1'b0, 4'b0000,2'd0,1'b0,1'b0,1'b0,1'b0};
        vecs[14] = '{1'b0, 4'b0100, 1'b0,1'b0,1'b0,1'b0,1'b0,4'd0,1'b0, 4'b0000,2'd0,1'b0,1'b0,1'b0,1'b0};
        vecs[15] = '{1'b0, 4'b0100, 1'b1,1'b0,1'b0,1'b0,1'b0,4'd0,1'b0, 4'b0100,2'd2,1'b1,1'b0,1'b0,1'b0};
        vecs[16] = '{1'b0, 4'b0100, 1'b0,1'b0,1'b0,1'b0,1'b0,4'd0,1'b1, 4'b0100,2'd2,1'b1,1'b1,1'b0,1'b0};
        vecs[17] = '{1'b0, 4'b0100, 1'b0,1'b0,1'b0,1'b0,1'b0,4'd0,1'b1, 4'b0000,2'd0,1'b0,1'b0,1'b0,1'b0};
        vecs[18] = '{1'b0, 4'b0100, 1'b0,1'b1,1'b0,1'b0,1'b0,4'd0,1'b1, 4'b0100,2'd2,1'b1,1'b0,1'b0,1'b0};
        vecs[19] = '{1'b0, 4'b0100, 1'b0,1'b0,1'b0,1'b0,1'b0,4'd0,1'b1, 4'b0100,2'd2,1'b1,1'b0,1'b0,1'b0};
        vecs[20] = '{1'b0, 4'b0100, 1'b0,1'b0,1'b0,1'b0,1'b0,4'd0,1'b0, 4'b0100,2'd2,1'b1,1'b0,1'b0,1'b0};
        vecs[21] = '{1'b0, 4'b0100, 1'b0,1'b0,1'b0,1'b0,1'b0,4'd0,1'b1, 4'b0100,2'd2,1'b1,1'b1,1'b0,1'b0};
        vecs[22] = '{1'b0, 4'b0011, 1'b0,1'b0,1'b0,1'b0,1'b0,4'd0,1'b0, 4'b0000,2'd0,1'b0,1'b0,1'b0,1'b0};
        vecs[23] = '{1'b0, 4'b0011, 1'b0,1'b0,1'b0,1'b0,1'b0,4'd0,1'b0, 4'b0001,2'd0,1'b1,1'b0,1'b0,1'b0};
        vecs[24] = '{1'b0, 4'b0010, 1'b0,1'b0,1'b0,1'b0,1'b0,4'd0,1'b0, 4'b0001,2'd0,1'b1,1'b0,1'b0,1'b0};
        vecs[25] = '{1'b0, 4'b0010, 1'b0,1'b0,1'b0,1'b0,1'b0,4'd0,1'b0, 4'b0000,2'd0,1'b0,1'b0,1'b0,1'b0};
        vecs[26] = '{1'b0, 4'b0010, 1'b1,1'b0,1'b0,1'b0,1'b0,4'd0,1'b0, 4'b0010,2'd1,1'b1,1'b0,1'b0,1'b0};
        vecs[27] = '{1'b0, 4'b0010, 1'b0,1'b0,1'b0,1'b0,1'b0,4'd0,1'b0, 4'b0010,2'd1,1'b1,1'b0,1'b0,1'b0};
        vecs[28] = '{1'b1, 4'b0011, 1'b0,1'b0,1'b1,1'b1,1'b1,T,   1'b0, 4'b0010,2'd1,1'b1,1'b0,1'b0,1'b1};
        vecs[29] = '{1'b0, 4'b0011, 1'b0,1'b0,1'b0,1'b0,1'b0,4'd0,1'b0, 4'b0000,2'd0,1'b0,1'b0,1'b0,1'b0};
        vecs[30] = '{1'b0, 4'b0011, 1'b0,1'b0,1'b0,1'b0,1'b0,4'd0,1'b0, 4'b0001,2'd0,1'b1,1'b0,1'b0,1'b0};
        vecs[31] = '{1'b0, 4'b0000, 1'b0,1'b0,1'b0,1'b0,1'b0,4'd0,1'b0, 4'b0001,2'd0,1'b1,1'b0,1'b0,1'b0};
        vecs[32] = '{1'b0, 4'b0000, 1'b0,1'b0,1'b0,1'b0,1'b0,4'd0,1'b0, 4'b0000,2'd0,1'b0,1'b0,1'b0,1'b0};

        drive(1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
        tick();
        tick();

        // ---------------- vector table ----------------
        for (int i = 0; i < 33; i++) begin
            drive(vecs[i].rst, vecs[i].req, vecs[i].khs, vecs[i].bhs, vecs[i].ov,
                  vecs[i].ordy, vecs[i].eot, vecs[i].typ, vecs[i].auth);
            #1;
            chk($sformatf("v%0d gnt", i), {4'b0, bus.gnt}, {4'b0, vecs[i].e_gnt});
            chk($sformatf("v%0d busy", i), {7'b0, bus.busy}, {7'b0, vecs[i].e_busy});
            chk($sformatf("v%0d op_done", i), {7'b0, bus.op_done}, {7'b0, vecs[i].e_done});
            chk($sformatf("v%0d timeout", i), {7'b0, bus.timeout}, {7'b0, vecs[i].e_to});
            chk($sformatf("v%0d core_rst", i), {7'b0, bus.core_rst}, {7'b0, vecs[i].e_crst});
            if (vecs[i].e_busy) begin
                chk($sformatf("v%0d gnt_id", i), {6'b0, bus.gnt_id}, {6'b0, vecs[i].e_id});
            end
            tick();
        end

        // ---------------- watchdog abort (last owner = 0) ----------------
        drive(1'b0, 4'b0010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
        #1;
        chk("to idle gnt", {4'b0, bus.gnt}, 8'h00);
        tick();
        drive(1'b0, 4'b0010, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
        #1;
        chk("to grant gnt", {4'b0, bus.gnt}, 8'h02);
        tick();
        for (int k = 1; k <= 16; k++) begin
            // owner request withdrawn while ACTIVE: must be ignored
            drive(1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
            #1;
            chk($sformatf("to k%0d timeout", k), {7'b0, bus.timeout}, {7'b0, (k == 16)});
            chk($sformatf("to k%0d gnt", k), {4'b0, bus.gnt}, 8'h02);
            tick();
        end
        for (int f = 1; f <= 2; f++) begin
            drive(1'b0, 4'b1010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
            #1;
            chk($sformatf("flush%0d core_rst", f), {7'b0, bus.core_rst}, 8'h01);
            chk($sformatf("flush%0d gnt", f), {4'b0, bus.gnt}, 8'h00);
            chk($sformatf("flush%0d busy", f), {7'b0, bus.busy}, 8'h01);
            chk($sformatf("flush%0d timeout", f), {7'b0, bus.timeout}, 8'h00);
            tick();
        end
        #1;
        chk("post-flush core_rst", {7'b0, bus.core_rst}, 8'h00);
        chk("post-flush busy", {7'b0, bus.busy}, 8'h00);
        chk("post-flush gnt", {4'b0, bus.gnt}, 8'h00);
        tick();
        // last owner was 1, so the search starts at 2 and finds requester 3
        drive(1'b0, 4'b1010, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
        #1;
        chk("rr-after-timeout gnt", {4'b0, bus.gnt}, 8'h08);
        chk("rr-after-timeout gnt_id", {6'b0, bus.gnt_id}, 8'h03);
        tick();

        // ---------------- completion coincident with expiry ----------------
        for (int k = 1; k <= 16; k++) begin
            if (k == 16) begin
                drive(1'b0, 4'b1010, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, T, 1'b0);
            end else begin
                drive(1'b0, 4'b1010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
            end
            #1;
            chk($sformatf("race k%0d op_done", k), {7'b0, bus.op_done}, {7'b0, (k == 16)});
            chk($sformatf("race k%0d timeout", k), {7'b0, bus.timeout}, 8'h00);
            tick();
        end
        drive(1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
        #1;
        chk("race after core_rst", {7'b0, bus.core_rst}, 8'h00);
        chk("race after busy", {7'b0, bus.busy}, 8'h00);
        chk("race after gnt", {4'b0, bus.gnt}, 8'h00);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/ascon_arbiter.md
ASCON_ARBITER -- requirements
Module: ascon_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 4, number of requesters sharing one ascon_core (2..8).
REQ-002 SHALL have parameter TIMEOUT_CYC, default 1024, idle cycles tolerated inside an owned operation before abort.
REQ-003 SHALL have parameter FLUSH_CYC, default 2, cycles core_rst is held after an abort.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 req  input  N_REQ  per-requester request for exclusive use of the core.
REQ-007 gnt  output  N_REQ  one-hot registered grant; the external mux steers core ports to the granted requester.
REQ-008 gnt_id  output  $clog2(N_REQ)  index of the current owner; valid while busy=1.
REQ-009 busy  output  1  high in every state except IDLE.
REQ-010 op_done  output  1  one-cycle pulse on normal completion of the owned operation.
REQ-011 timeout  output  1  one-cycle pulse on watchdog abort.
REQ-012 core_rst  output  1  reset to ascon_core: rst OR flush-active.
REQ-013 key_valid, key_ready  input  1 each  snooped core key handshake.
REQ-014 bdi_valid, bdi_ready  input  1 each  snooped core bdi handshake.
REQ-015 bdo_valid, bdo_ready, bdo_eot  input  1 each  snooped core bdo handshake.
REQ-016 bdo_type  input  4  snooped core output type (D_TAG, D_HASH from config_core.vh).
REQ-017 auth_valid  input  1  snooped core authentication-result valid.

Function
REQ-018 SHALL implement states IDLE, GRANT, ACTIVE, FLUSH.
REQ-019 IDLE: if any req bit set, SHALL select the first set bit searching round-robin from (last_owner+1) mod N_REQ, assert that gnt bit and enter GRANT on the next edge (1-cycle grant latency).
REQ-020 GRANT: on first handshake (key_valid&key_ready or bdi_valid&bdi_ready) SHALL enter ACTIVE; if owner's req drops before any handshake, SHALL clear gnt and return to IDLE next cycle.
REQ-021 ACTIVE: owner's req SHALL be ignored; ownership held until completion or timeout.
REQ-022 Completion = (bdo_valid&bdo_ready&bdo_eot&bdo_type∈{D_TAG,D_HASH}) or rising edge of auth_valid; SHALL pulse op_done that cycle, clear gnt, enter IDLE next edge.
REQ-023 last_owner SHALL update to gnt_id on completion, release in GRANT, or timeout.
REQ-024 Watchdog counter SHALL clear on entry to GRANT and on every snooped handshake; SHALL increment each other GRANT/ACTIVE cycle; at TIMEOUT_CYC SHALL pulse timeout, clear gnt, enter FLUSH.
REQ-025 FLUSH SHALL assert core_rst for exactly FLUSH_CYC cycles, then enter IDLE; no grant issued during FLUSH.
REQ-026 Completion and timeout in same cycle: completion SHALL win; timeout not pulsed, no FLUSH.
REQ-027 gnt SHALL never have more than one bit set; gnt SHALL be zero in IDLE and FLUSH.
REQ-028 auth_valid edge detector SHALL be primed so an auth_valid already high at GRANT entry is not counted.

Reset
REQ-029 On rst: state IDLE, gnt=0, gnt_id=0, busy=0, op_done=0, timeout=0, last_owner=N_REQ-1 (first search starts at 0), watchdog=0.
REQ-030 core_rst SHALL follow rst in the same cycle; rst mid-operation SHALL abort without pulsing op_done or timeout.

Verification
REQ-031 req=4'b1010 from reset -> gnt=4'b0010 one cycle later; after op_done, req held -> next gnt=4'b1000.
REQ-032 Owner 0 encrypt: D_TAG beat with bdo_eot=1 accepted -> op_done pulse same cycle, gnt=0 next cycle, busy=0.
REQ-033 Owner decrypt: auth_valid 0->1 -> op_done pulse; auth_valid held high into next grant -> no second op_done.
REQ-034 TIMEOUT_CYC=16, no handshake for 16 cycles in ACTIVE -> timeout pulse, core_rst high exactly 2 cycles, then IDLE, round-robin advanced.
REQ-035 req drops in GRANT before handshake -> gnt cleared next cycle, no op_done.
REQ-036 rst asserted mid-ACTIVE -> core_rst=1 same cycle, all outputs zero next cycle, next grant to requester 0.
